pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
Second-generation control unit for the 5-stage RISC-V core. Decodes opcode/funct3/funct7 in ID and carries control through the ID/EX, EX/MEM and MEM/WB pipeline registers. Supports bubble insertion for load-use stalls and branch flushes, a global freeze for slow memory, and branch resolution in EX for all six RV32I conditions. Adds illegal-instruction detection and a retired-instruction counter.

Parameters:
REG_AW, 5, register address width (rd path)
ALUCTRL_W, 4, ALU control width; must be >=4
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
valid_d  in  1  ID holds a real instruction
op  in  7  opcode (ID)
funct3  in  3  funct3 (ID)
funct7  in  7  funct7 (ID)
rd_d  in  REG_AW  destination register (ID)
stall_d  in  1  load-use stall: bubble into EX
flush_e  in  1  branch/jump taken: bubble into EX
mem_stall  in  1  freeze all control pipeline registers
zero_e  in  1  ALU result == 0
lt_e  in  1  signed less-than
ltu_e  in  1  unsigned less-than
illegal_d  out  1  combinational: valid_d and undecodable
alu_control_e  out  ALUCTRL_W  ALU operation (EX)
alusrc_e  out  1  operand B = immediate (EX)
pcsrc_e  out  1  redirect PC (EX)
rd_e, rd_m, rd_w  out  REG_AW  destination per stage
regwrite_e, regwrite_m, regwrite_w  out  1  register write per stage
memwrite_m  out  1  data-memory write
result_src_m, result_src_w  out  2  00 ALU, 01 memory, 10 PC+4
illegal_sticky  out  1  set on first illegal instruction entering EX
retired_cnt  out  CNT_W  count of valid instructions leaving WB

Behaviour:
- Reset (rst=0, async): every pipeline register and output register is 0; illegal_sticky=0; retired_cnt=0. Mid-operation reset discards in-flight instructions immediately.
- Decode, combinational in ID:
  - R 0110011: regwrite, ALU op from funct3/funct7.
  - I-ALU 0010011: regwrite, alusrc.
  - Load 0000011: regwrite, alusrc, add, result 01.
  - Store 0100011: memwrite, alusrc, add.
  - Branch 1100011: branch, sub.
  - LUI 0110111: regwrite, alusrc, pass-B.
  - JAL 1101111: regwrite, jump, result 10.
  - Any other opcode, branch funct3 010/011, or R-type funct7 not in {0000000, 0100000}: illegal; decoded controls are all 0.
- ALU encoding: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 pass-B.
  - sub and sra require funct7[5]=1: R-type only for sub; both R and I for sra.
  - I-type funct3=000 is always add.
- rd=0 forces regwrite=0 at decode.
- Normal advance per clock: ID decode -> EX register -> MEM register -> WB register. Latency ID->EX is 1 cycle, ID->MEM 2, ID->WB 3.
- Bubble: if stall_d or flush_e (and not mem_stall), the EX register loads all zeros (valid=0, rd=0). MEM and WB still advance.
- mem_stall=1: all three registers hold; stall_d and flush_e are ignored that cycle; retired_cnt holds. The hazard unit keeps flush_e asserted until mem_stall drops.
- pcsrc_e, combinational from the EX register:
  - valid_e and (jump_e or branch_e and cond).
  - cond: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - pcsrc_e=0 while the EX slot holds a bubble.
- illegal_sticky sets when an illegal valid instruction is latched into EX; it clears only on reset.
- retired_cnt increments by 1 each non-frozen cycle in which valid_w=1; it wraps modulo 2^CNT_W.

Test Plan:
- Reset, then `add x3,x1,x2` with valid_d=1 (op 0110011, f3 000, f7 0) -> next cycle alu_control_e=0, regwrite_e=1, rd_e=3; cycle 3 regwrite_w=1, rd_w=3; retired_cnt becomes 1 one cycle later.
- `bne` (f3 001) in EX with zero_e=0 -> pcsrc_e=1. The same instruction with zero_e=1 -> pcsrc_e=0. `bgeu` with ltu_e=1 -> pcsrc_e=0.
- `lw x5` followed by stall_d=1 for one cycle -> EX holds a bubble (regwrite_e=0, rd_e=0); lw reaches MEM with result_src_m=01 and rd_m=5.
- mem_stall=1 for 3 cycles with flush_e=1 -> rd_e/rd_m/rd_w and retired_cnt frozen. After release with flush_e still 1 -> EX bubble.
- op=1111111 valid -> illegal_d=1; next cycle illegal_sticky=1 with regwrite_e=0. Assert rst=0 mid-stream -> all outputs 0 asynchronously.
- `addi x0,x0,1` -> regwrite_e=0. `srai` (f7 0100000, f3 101) -> alu_control_e=9. Preload retired_cnt near 2^CNT_W-1 (or use CNT_W=4) -> wraps to 0.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - ID decode plus ID/EX, EX/MEM, MEM/WB control pipeline for a 5-stage RV32I core
module pipelined_control_unit #(
    parameter int REG_AW    = 5,
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_d,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [REG_AW-1:0]    rd_d,
    input  logic                 stall_d,
    input  logic                 flush_e,
    input  logic                 mem_stall,
    input  logic                 zero_e,
    input  logic                 lt_e,
    input  logic                 ltu_e,
    output logic                 illegal_d,
    output logic [ALUCTRL_W-1:0] alu_control_e,
    output logic                 alusrc_e,
    output logic                 pcsrc_e,
    output logic [REG_AW-1:0]    rd_e,
    output logic [REG_AW-1:0]    rd_m,
    output logic [REG_AW-1:0]    rd_w,
    output logic                 regwrite_e,
    output logic                 regwrite_m,
    output logic                 regwrite_w,
    output logic                 memwrite_m,
    output logic [1:0]           result_src_m,
    output logic [1:0]           result_src_w,
    output logic                 illegal_sticky,
    output logic [CNT_W-1:0]     retired_cnt
);
    localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(9);
    localparam logic [ALUCTRL_W-1:0] ALU_PASSB = ALUCTRL_W'(10);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

    // Subtract is only reachable from R-type; I-type funct3=000 is always add.
    function automatic logic [ALUCTRL_W-1:0] alu_from_f3(input logic [2:0] f3,
                                                         input logic f7b5,
                                                         input logic is_r);
        case (f3)
            3'b000:  alu_from_f3 = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_f3 = ALU_SLL;
            3'b010:  alu_from_f3 = ALU_SLT;
            3'b011:  alu_from_f3 = ALU_SLTU;
            3'b100:  alu_from_f3 = ALU_XOR;
            3'b101:  alu_from_f3 = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

    logic                 dec_regwrite, dec_memwrite, dec_alusrc, dec_branch, dec_jump, dec_illegal;
    logic [1:0]           dec_result;
    logic [ALUCTRL_W-1:0] dec_alu;

    always_comb begin
        dec_regwrite = 1'b0;
        dec_memwrite = 1'b0;
        dec_alusrc   = 1'b0;
        dec_branch   = 1'b0;
        dec_jump     = 1'b0;
        dec_illegal  = 1'b0;
        dec_result   = 2'b00;
        dec_alu      = ALU_ADD;
        case (op)
            7'b0110011: begin
                dec_regwrite = 1'b1;
                dec_alu      = alu_from_f3(funct3, funct7[5], 1'b1);
                dec_illegal  = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            7'b0010011: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_alu      = alu_from_f3(funct3, funct7[5], 1'b0);
            end
            7'b0000011: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_result   = 2'b01;
            end
            7'b0100011: begin
                dec_memwrite = 1'b1;
                dec_alusrc   = 1'b1;
            end
            7'b1100011: begin
                dec_branch  = 1'b1;
                dec_alu     = ALU_SUB;
                dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            7'b0110111: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_alu      = ALU_PASSB;
            end
            7'b1101111: begin
                dec_regwrite = 1'b1;
                dec_jump     = 1'b1;
                dec_result   = 2'b10;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_regwrite = 1'b0;
            dec_memwrite = 1'b0;
            dec_alusrc   = 1'b0;
            dec_branch   = 1'b0;
            dec_jump     = 1'b0;
            dec_result   = 2'b00;
            dec_alu      = ALU_ADD;
        end
        if (rd_d == '0) dec_regwrite = 1'b0;
    end

    assign illegal_d = valid_d && dec_illegal;

    logic       valid_e, memwrite_e, branch_e, jump_e, valid_m, valid_w;
    logic [1:0] result_src_e;
    logic [2:0] funct3_e;
    logic       load_e;

    // A non-instruction in ID enters EX as a bubble, same as a stall or flush.
    assign load_e = valid_d && !stall_d && !flush_e;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_e        <= 1'b0;
            regwrite_e     <= 1'b0;
            memwrite_e     <= 1'b0;
            result_src_e   <= 2'b00;
            branch_e       <= 1'b0;
            jump_e         <= 1'b0;
            alusrc_e       <= 1'b0;
            alu_control_e  <= '0;
            funct3_e       <= 3'b000;
            rd_e           <= '0;
            valid_m        <= 1'b0;
            regwrite_m     <= 1'b0;
            memwrite_m     <= 1'b0;
            result_src_m   <= 2'b00;
            rd_m           <= '0;
            valid_w        <= 1'b0;
            regwrite_w     <= 1'b0;
            result_src_w   <= 2'b00;
            rd_w           <= '0;
            illegal_sticky <= 1'b0;
            retired_cnt    <= '0;
        end else if (!mem_stall) begin
            valid_e       <= load_e;
            regwrite_e    <= load_e && dec_regwrite;
            memwrite_e    <= load_e && dec_memwrite;
            result_src_e  <= load_e ? dec_result : 2'b00;
            branch_e      <= load_e && dec_branch;
            jump_e        <= load_e && dec_jump;
            alusrc_e      <= load_e && dec_alusrc;
            alu_control_e <= load_e ? dec_alu : '0;
            funct3_e      <= load_e ? funct3 : 3'b000;
            rd_e          <= load_e ? rd_d : '0;
            valid_m       <= valid_e;
            regwrite_m    <= regwrite_e;
            memwrite_m    <= memwrite_e;
            result_src_m  <= result_src_e;
            rd_m          <= rd_e;
            valid_w       <= valid_m;
            regwrite_w    <= regwrite_m;
            result_src_w  <= result_src_m;
            rd_w          <= rd_m;
            if (load_e && dec_illegal) illegal_sticky <= 1'b1;
            if (valid_w) retired_cnt <= retired_cnt + CNT_ONE;
        end
    end

    logic cond_e;

    always_comb begin
        cond_e = 1'b0;
        case (funct3_e)
            3'b000:  cond_e = zero_e;
            3'b001:  cond_e = !zero_e;
            3'b100:  cond_e = lt_e;
            3'b101:  cond_e = !lt_e;
            3'b110:  cond_e = ltu_e;
            3'b111:  cond_e = !ltu_e;
            default: cond_e = 1'b0;
        endcase
    end

    assign pcsrc_e = valid_e && (jump_e || (branch_e && cond_e));
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - scoreboard bench for pipelined_control_unit with a behavioural pipeline model
module tb_pipelined_control_unit;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                           OP_S = 7'b0100011, OP_B = 7'b1100011, OP_LUI = 7'b0110111,
                           OP_JAL = 7'b1101111;

    typedef struct packed {
        logic rst, valid;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rd;
        logic stall, flush, mstall, zero, lt, ltu;
    } in_t;

    typedef struct packed {
        logic valid, illegal, rw, mw, br, jmp, asrc;
        logic [1:0] res;
        logic [3:0] alu;
        logic [2:0] f3;
        logic [4:0] rd;
    } ctl_t;

    typedef struct packed {
        logic illegal_d;
        logic [3:0] alu_e;
        logic alusrc_e, pcsrc_e;
        logic [4:0] rd_e, rd_m, rd_w;
        logic rw_e, rw_m, rw_w, mw_m;
        logic [1:0] rs_m, rs_w;
        logic sticky;
        logic [3:0] cnt;
    } out_t;

    logic clk = 1'b0;
    logic rst, valid_d, stall_d, flush_e, mem_stall, zero_e, lt_e, ltu_e;
    logic [6:0] op, funct7;
    logic [2:0] funct3;
    logic [4:0] rd_d;
    logic illegal_d, alusrc_e, pcsrc_e, regwrite_e, regwrite_m, regwrite_w, memwrite_m, illegal_sticky;
    logic [3:0] alu_control_e, retired_cnt;
    logic [4:0] rd_e, rd_m, rd_w;
    logic [1:0] result_src_m, result_src_w;

    always #5 clk = ~clk;

    pipelined_control_unit #(.REG_AW(5), .ALUCTRL_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .op(op), .funct3(funct3), .funct7(funct7),
        .rd_d(rd_d), .stall_d(stall_d), .flush_e(flush_e), .mem_stall(mem_stall),
        .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e), .illegal_d(illegal_d),
        .alu_control_e(alu_control_e), .alusrc_e(alusrc_e), .pcsrc_e(pcsrc_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_e(regwrite_e),
        .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .memwrite_m(memwrite_m),
        .result_src_m(result_src_m), .result_src_w(result_src_w),
        .illegal_sticky(illegal_sticky), .retired_cnt(retired_cnt)
    );

    int errors = 0;
    int checks = 0;
    out_t exp_q[$];

    // ALU code indexed by funct3 before the funct7[5] variants are applied
    int alu_tbl[8] = '{0, 7, 5, 6, 4, 8, 3, 2};

    ctl_t m_ex, m_mem, m_wb;
    logic m_sticky;
    logic [3:0] m_cnt;
    in_t cur;

    function automatic ctl_t decode(in_t s);
        ctl_t c;
        logic bad;
        c = '0;
        bad = 1'b0;
        if (!s.valid) return c;
        if (s.op == OP_R) begin
            c.rw = 1; c.alu = 4'(alu_tbl[s.f3]);
            if (s.f3 == 3'd0 && s.f7[5]) c.alu = 4'd1;
            if (s.f3 == 3'd5 && s.f7[5]) c.alu = 4'd9;
            bad = !(s.f7 == 7'h00 || s.f7 == 7'h20);
        end else if (s.op == OP_I) begin
            c.rw = 1; c.asrc = 1; c.alu = 4'(alu_tbl[s.f3]);
            if (s.f3 == 3'd5 && s.f7[5]) c.alu = 4'd9;
        end else if (s.op == OP_L) begin
            c.rw = 1; c.asrc = 1; c.res = 2'd1;
        end else if (s.op == OP_S) begin
            c.mw = 1; c.asrc = 1;
        end else if (s.op == OP_B) begin
            c.br = 1; c.alu = 4'd1;
            bad = (s.f3 == 3'd2 || s.f3 == 3'd3);
        end else if (s.op == OP_LUI) begin
            c.rw = 1; c.asrc = 1; c.alu = 4'd10;
        end else if (s.op == OP_JAL) begin
            c.rw = 1; c.jmp = 1; c.res = 2'd2;
        end else begin
            bad = 1'b1;
        end
        if (bad) c = '0;
        if (s.rd == 5'd0) c.rw = 1'b0;
        c.valid = 1'b1;
        c.illegal = bad;
        c.f3 = s.f3;
        c.rd = s.rd;
        return c;
    endfunction

    function automatic logic branch_taken(logic [2:0] f3, logic z, logic l, logic lu);
        logic base;
        base = f3[2] ? (f3[1] ? lu : l) : z;
        return base ^ f3[0];
    endfunction

    task automatic model_edge(in_t s);
        if (!s.rst) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_sticky = 0; m_cnt = 0;
        end else if (!s.mstall) begin
            if (m_wb.valid) m_cnt = m_cnt + 4'd1;
            m_wb = m_mem;
            m_mem = m_ex;
            m_ex = (s.stall || s.flush) ? ctl_t'('0) : decode(s);
            if (m_ex.valid && m_ex.illegal) m_sticky = 1'b1;
        end
    endtask

    function automatic out_t expected(in_t s);
        out_t o;
        ctl_t d;
        d = decode(s);
        o.illegal_d = d.illegal;
        o.alu_e = m_ex.alu;
        o.alusrc_e = m_ex.asrc;
        o.pcsrc_e = m_ex.valid && (m_ex.jmp || (m_ex.br && branch_taken(m_ex.f3, s.zero, s.lt, s.ltu)));
        o.rd_e = m_ex.rd; o.rd_m = m_mem.rd; o.rd_w = m_wb.rd;
        o.rw_e = m_ex.rw; o.rw_m = m_mem.rw; o.rw_w = m_wb.rw;
        o.mw_m = m_mem.mw;
        o.rs_m = m_mem.res; o.rs_w = m_wb.res;
        o.sticky = m_sticky;
        o.cnt = m_cnt;
        return o;
    endfunction

    task automatic apply(in_t s);
        rst = s.rst; valid_d = s.valid; op = s.op; funct3 = s.f3; funct7 = s.f7; rd_d = s.rd;
        stall_d = s.stall; flush_e = s.flush; mem_stall = s.mstall;
        zero_e = s.zero; lt_e = s.lt; ltu_e = s.ltu;
    endtask

    // One cycle: model the edge that just happened, then drive new inputs and queue the response.
    task automatic step(in_t s);
        @(posedge clk);
        #1;
        model_edge(cur);
        cur = s;
        apply(s);
        if (!s.rst) model_edge(s);
        exp_q.push_back(expected(s));
    endtask

    function automatic in_t mk(logic [6:0] o, logic [2:0] f3, logic [6:0] f7, logic [4:0] rd);
        in_t s;
        s = '0;
        s.rst = 1; s.valid = 1; s.op = o; s.f3 = f3; s.f7 = f7; s.rd = rd;
        return s;
    endfunction

    function automatic in_t idle();
        in_t s;
        s = '0;
        s.rst = 1;
        return s;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t e;
            e = exp_q.pop_front();
            chk("illegal_d", 32'(illegal_d), 32'(e.illegal_d));
            chk("alu_control_e", 32'(alu_control_e), 32'(e.alu_e));
            chk("alusrc_e", 32'(alusrc_e), 32'(e.alusrc_e));
            chk("pcsrc_e", 32'(pcsrc_e), 32'(e.pcsrc_e));
            chk("rd_e", 32'(rd_e), 32'(e.rd_e));
            chk("rd_m", 32'(rd_m), 32'(e.rd_m));
            chk("rd_w", 32'(rd_w), 32'(e.rd_w));
            chk("regwrite_e", 32'(regwrite_e), 32'(e.rw_e));
            chk("regwrite_m", 32'(regwrite_m), 32'(e.rw_m));
            chk("regwrite_w", 32'(regwrite_w), 32'(e.rw_w));
            chk("memwrite_m", 32'(memwrite_m), 32'(e.mw_m));
            chk("result_src_m", 32'(result_src_m), 32'(e.rs_m));
            chk("result_src_w", 32'(result_src_w), 32'(e.rs_w));
            chk("illegal_sticky", 32'(illegal_sticky), 32'(e.sticky));
            chk("retired_cnt", 32'(retired_cnt), 32'(e.cnt));
        end
    end

    initial begin
        in_t s;
        cur = '0;
        apply(cur);
        m_ex = '0; m_mem = '0; m_wb = '0; m_sticky = 0; m_cnt = 0;
        step(cur);
        step(cur);

        step(mk(OP_R, 3'd0, 7'h00, 5'd3));
        repeat (5) step(idle());

        step(mk(OP_B, 3'd1, 7'h00, 5'd0));
        s = idle(); s.zero = 0; step(s);
        step(mk(OP_B, 3'd1, 7'h00, 5'd0));
        s = idle(); s.zero = 1; step(s);
        step(mk(OP_B, 3'd7, 7'h00, 5'd0));
        s = idle(); s.ltu = 1; step(s);

        step(mk(OP_L, 3'd2, 7'h00, 5'd5));
        s = mk(OP_R, 3'd0, 7'h00, 5'd6); s.stall = 1; step(s);
        repeat (3) step(idle());

        step(mk(OP_R, 3'd0, 7'h00, 5'd7));
        step(mk(OP_I, 3'd0, 7'h00, 5'd8));
        step(mk(OP_R, 3'd4, 7'h00, 5'd9));
        for (int i = 0; i < 3; i++) begin
            s = mk(OP_JAL, 3'd0, 7'h00, 5'd10); s.mstall = 1; s.flush = 1; step(s);
        end
        s = mk(OP_JAL, 3'd0, 7'h00, 5'd10); s.flush = 1; step(s);
        repeat (3) step(idle());

        step(mk(7'h7f, 3'd0, 7'h00, 5'd11));
        step(mk(OP_I, 3'd0, 7'h00, 5'd0));
        step(mk(OP_I, 3'd5, 7'h20, 5'd4));
        step(mk(OP_LUI, 3'd0, 7'h00, 5'd12));
        step(idle());
        step(idle());
        step(cur);
        step(idle());

        for (int i = 0; i < 900; i++) begin
            int pick;
            s = '0;
            s.rst = ($urandom_range(0, 99) != 0);
            s.valid = s.rst && ($urandom_range(0, 9) != 0);
            pick = $urandom_range(0, 8);
            case (pick)
                0, 8: s.op = OP_R;
                1: s.op = OP_I;
                2: s.op = OP_L;
                3: s.op = OP_S;
                4: s.op = OP_B;
                5: s.op = OP_LUI;
                6: s.op = OP_JAL;
                default: s.op = 7'($urandom);
            endcase
            s.f3 = 3'($urandom);
            case ($urandom_range(0, 9))
                0, 1: s.f7 = 7'h20;
                2: s.f7 = 7'($urandom);
                default: s.f7 = 7'h00;
            endcase
            s.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            s.stall = ($urandom_range(0, 9) == 0);
            s.flush = ($urandom_range(0, 9) == 0);
            s.mstall = ($urandom_range(0, 6) == 0);
            s.zero = 1'($urandom); s.lt = 1'($urandom); s.ltu = 1'($urandom);
            step(s);
        end
        repeat (4) step(idle());

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
